// File: rtl/led_mode_controller_if.sv
// Signal bundle between the button/LED board logic and led_mode_controller.
// Handshake: there is no valid/ready pair. sw_db is sampled on every rising
// clock edge; led_o and mode_o are registered and valid every cycle. long_press_o
// is a single-cycle strobe that is valid in the cycle it is high.
interface led_mode_controller_if;
  logic       sw_db;
  logic       led_o;
  logic [2:0] mode_o;
  logic       long_press_o;

  // Board side: drives the debounced button, observes the LED state.
  modport master (
    output sw_db,
    input  led_o,
    input  mode_o,
    input  long_press_o
  );

  // Controller side.
  modport slave (
    input  sw_db,
    output led_o,
    output mode_o,
    output long_press_o
  );
endinterface

// File: rtl/led_mode_controller.sv
// Status LED sequencer: each short press/release steps OFF->ON->SLOW->FAST->OFF,
// a long press forces OFF and emits a one-cycle long_press_o strobe.
// Optional macro LED_DIM_EN inserts a PWM-dimmed DIM mode after FAST.
// The current mode register is the controller state and is exported on mode_o.
module led_mode_controller #(
  parameter int LONG_PRESS_CYCLES = 25000000,
  parameter int BLINK_SLOW_HALF   = 12500000,
  parameter int BLINK_FAST_HALF   = 3125000,
  parameter int PWM_PERIOD        = 16,
  parameter int PWM_DUTY          = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  led_mode_controller_if.slave bus
);

  localparam logic [2:0] MODE_OFF  = 3'd0;
  localparam logic [2:0] MODE_ON   = 3'd1;
  localparam logic [2:0] MODE_SLOW = 3'd2;
  localparam logic [2:0] MODE_FAST = 3'd3;
  localparam logic [2:0] MODE_DIM  = 3'd4;

  // Hold counter saturates at LONG_PRESS_CYCLES, so it needs that value to fit.
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0] HOLD_FIRE = HW'(LONG_PRESS_CYCLES - 1);

  // Blink counter only reaches HALF-1 of the larger half-period.
  localparam int BLINK_MAX = (BLINK_SLOW_HALF > BLINK_FAST_HALF) ? BLINK_SLOW_HALF
                                                                 : BLINK_FAST_HALF;
  localparam int BW = (BLINK_MAX > 1) ? $clog2(BLINK_MAX) : 1;
  localparam logic [BW-1:0] SLOW_LAST = BW'(BLINK_SLOW_HALF - 1);
  localparam logic [BW-1:0] FAST_LAST = BW'(BLINK_FAST_HALF - 1);

  // Elaboration-time sanity checks on the configuration.
  generate
    if (LONG_PRESS_CYCLES < 2) begin : g_bad_long
      $error("LONG_PRESS_CYCLES must be at least 2");
    end
    if (BLINK_SLOW_HALF < 1 || BLINK_FAST_HALF < 1) begin : g_bad_blink
      $error("blink half-periods must be at least 1");
    end
    if (PWM_DUTY <= 0 || PWM_DUTY >= PWM_PERIOD) begin : g_bad_pwm
      $error("PWM_DUTY must satisfy 0 < PWM_DUTY < PWM_PERIOD");
    end
  endgenerate

`ifdef LED_DIM_EN
  localparam int PW = $clog2(PWM_PERIOD);
  localparam logic [PW-1:0] PWM_LAST = PW'(PWM_PERIOD - 1);
  localparam logic [PW-1:0] PWM_ON   = PW'(PWM_DUTY);
  logic [PW-1:0] pwm_q, pwm_d;
`endif

  logic          sw_q, sw_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          long_fired_q, long_fired_d;
  logic [BW-1:0] blink_q, blink_d;
  logic [2:0]    mode_q, mode_d;
  logic          led_q, led_d;
  logic          long_press_q, long_press_d;

  logic          press_edge, release_edge, held;
  logic          mode_entry;
  logic [2:0]    next_mode;
  logic [BW-1:0] blink_last;

  assign press_edge   =  bus.sw_db & ~sw_q;
  assign release_edge = ~bus.sw_db &  sw_q;
  assign held         =  bus.sw_db &  sw_q;

  // Successor mode for a short press.
  always_comb begin
    next_mode = MODE_OFF;
    case (mode_q)
      MODE_OFF:  next_mode = MODE_ON;
      MODE_ON:   next_mode = MODE_SLOW;
      MODE_SLOW: next_mode = MODE_FAST;
`ifdef LED_DIM_EN
      MODE_FAST: next_mode = MODE_DIM;
      MODE_DIM:  next_mode = MODE_OFF;
`else
      MODE_FAST: next_mode = MODE_OFF;
`endif
      default:   next_mode = MODE_OFF;
    endcase
  end

  // Button edge handling, hold timing and mode selection.
  always_comb begin
    sw_d         = bus.sw_db;
    hold_d       = hold_q;
    long_fired_d = long_fired_q;
    long_press_d = 1'b0;
    mode_d       = mode_q;
    if (press_edge) begin
      hold_d       = HW'(1);
      long_fired_d = 1'b0;
    end else if (held) begin
      if (hold_q != HOLD_SAT) begin
        hold_d = hold_q + HW'(1);
      end
      // long_fired keeps a still-held button from pulsing twice.
      if (hold_q == HOLD_FIRE && !long_fired_q) begin
        long_fired_d = 1'b1;
        long_press_d = 1'b1;
        mode_d       = MODE_OFF;
      end
    end else if (release_edge) begin
      hold_d = '0;
      // The release that ends a long press must not also step the mode.
      if (!long_fired_q) begin
        mode_d = next_mode;
      end
    end
  end

  assign mode_entry = (mode_d != mode_q);
  assign blink_last = (mode_d == MODE_SLOW) ? SLOW_LAST : FAST_LAST;

  // LED drive for the mode being entered or held; counters restart on any mode change.
  always_comb begin
    blink_d = '0;
    led_d   = 1'b0;
`ifdef LED_DIM_EN
    pwm_d   = '0;
`endif
    case (mode_d)
      MODE_ON: led_d = 1'b1;
      MODE_SLOW, MODE_FAST: begin
        if (mode_entry) begin
          blink_d = '0;
          led_d   = 1'b1;
        end else if (blink_q == blink_last) begin
          blink_d = '0;
          led_d   = ~led_q;
        end else begin
          blink_d = blink_q + BW'(1);
          led_d   = led_q;
        end
      end
`ifdef LED_DIM_EN
      MODE_DIM: begin
        if (mode_entry || pwm_q == PWM_LAST) begin
          pwm_d = '0;
        end else begin
          pwm_d = pwm_q + PW'(1);
        end
        led_d = (pwm_d < PWM_ON);
      end
`endif
      default: led_d = 1'b0;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_q         <= 1'b0;
      hold_q       <= '0;
      long_fired_q <= 1'b0;
      blink_q      <= '0;
      mode_q       <= MODE_OFF;
      led_q        <= 1'b0;
      long_press_q <= 1'b0;
    end else begin
      sw_q         <= sw_d;
      hold_q       <= hold_d;
      long_fired_q <= long_fired_d;
      blink_q      <= blink_d;
      mode_q       <= mode_d;
      led_q        <= led_d;
      long_press_q <= long_press_d;
    end
  end

`ifdef LED_DIM_EN
  // PWM phase counter for DIM mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_q <= '0;
    end else begin
      pwm_q <= pwm_d;
    end
  end
`endif

  assign bus.led_o        = led_q;
  assign bus.mode_o       = mode_q;
  assign bus.long_press_o = long_press_q;

endmodule

// File: doc/led_mode_controller.md
Name: led_mode_controller

Overview:
- Sequencing controller for the board's status LED, driven by one debounced push-button.
- Counts button releases to step the LED through its modes: off, on, slow blink and fast blink.
- A long press forces the LED off.
- Sits downstream of the existing debounce filter and replaces the plain release-toggle logic as the owner of the LED output.

Parameters:
- LONG_PRESS_CYCLES, 25000000: cycles the button must be held to count as a long press; minimum 2.
- BLINK_SLOW_HALF, 12500000: half-period of slow blink, in cycles; minimum 1.
- BLINK_FAST_HALF, 3125000: half-period of fast blink, in cycles; minimum 1.
- PWM_PERIOD, 16: dim-mode PWM period, in cycles. Used only with LED_DIM_EN.
- PWM_DUTY, 4: dim-mode on-cycles per PWM period, with 0 < PWM_DUTY < PWM_PERIOD. Used only with LED_DIM_EN.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset: synchronous, active-high.
- sw_db  input  1  debounced button, 1 = pressed. Already synchronous to clk.
- led_o  output  1  registered LED drive, 1 = lit.
- mode_o  output  3  registered current mode: 0 OFF, 1 ON, 2 SLOW, 3 FAST, 4 DIM.
- long_press_o  output  1  one-cycle pulse when a long press is detected.

Behaviour:
- Reset (rst=1 at a clock edge) clears the following; reset has priority over all other events:
  - sw_q=0, hold_cnt=0, long_fired=0, blink_cnt=0.
  - mode_o=0, led_o=0, long_press_o=0.
- Edge detection: sw_q registers sw_db every cycle.
  - Press edge: sw_db=1 and sw_q=0.
  - Release edge: sw_db=0 and sw_q=1.
- Press edge: hold_cnt<=1, long_fired<=0.
- Button held (sw_db=1 and sw_q=1):
  - hold_cnt increments and saturates at LONG_PRESS_CYCLES.
  - In the cycle where hold_cnt==LONG_PRESS_CYCLES-1 and long_fired=0, at that edge: long_fired<=1, long_press_o<=1 for exactly one cycle, mode<=OFF, led_o<=0.
  - Result: exactly one pulse per press, LONG_PRESS_CYCLES cycles after the press edge.
  - A long press while already OFF still pulses; the mode stays OFF.
- Release edge:
  - If long_fired=1: no mode change.
  - Otherwise the mode advances at that edge: OFF->ON->SLOW->FAST->OFF. With LED_DIM_EN the sequence is FAST->DIM->OFF.
  - hold_cnt<=0 on every release edge.
- Mode outputs:
  - mode_o and led_o both change at the same edge as the triggering event; there is no extra latency stage.
  - OFF: led_o=0.
  - ON: led_o=1.
  - SLOW and FAST, on entry: blink_cnt<=0, led_o<=1. Then blink_cnt counts 0..HALF-1. At HALF-1 it wraps to 0 and led_o toggles, giving a square wave of period 2*HALF that starts lit.
- Mode-entry clearing: blink_cnt clears on every mode change. No counter carries over between modes.
- Reset while the button is held: because sw_q=0 after reset, a still-high sw_db produces a fresh press edge in the first cycle after reset. Hold timing restarts from that edge.
- Press and release edges are mutually exclusive. A release edge in the same cycle as long detection cannot occur, because detection requires sw_db=1.

Optional Feature:
- Macro: LED_DIM_EN.
- Defined:
  - Adds mode 4 DIM to the sequence: FAST->DIM->OFF.
  - In DIM a PWM counter counts 0..PWM_PERIOD-1 and wraps; led_o=1 while the counter is below PWM_DUTY.
  - The counter clears on DIM entry, so led_o=1 on the entry edge.
  - Long press from DIM gives OFF.
- Undefined:
  - FAST->OFF.
  - mode_o never equals 4 and mode_o[2] is constant 0.
  - No PWM logic is synthesized.

Test Plan:
All scenarios use LONG_PRESS_CYCLES=8, BLINK_SLOW_HALF=4, BLINK_FAST_HALF=2, PWM_PERIOD=4, PWM_DUTY=1.
- Reset: hold rst=1 for 3 cycles with sw_db toggling -> mode_o=0, led_o=0, long_press_o=0 throughout and on the first cycle after reset.
- Short presses: four presses of 3 cycles each, 5 cycles apart -> mode_o goes 1,2,3,0, each change at the edge after the release edge.
  - In ON: led_o=1.
  - In SLOW: led_o shows 4 cycles high, 4 low, starting high.
  - In FAST: 2 high, 2 low.
- Long press from SLOW: hold sw_db=1 for 12 cycles -> long_press_o high for exactly 1 cycle, 8 cycles after the press edge. mode_o=0, led_o=0 from that edge. The release causes no mode change, and the next short press gives mode_o=1.
- Long press from OFF: hold 10 cycles -> one pulse, mode_o stays 0, led_o stays 0.
- Reset mid-hold: button held in ON at hold_cnt=5, pulse rst for 1 cycle, keep sw_db=1 -> mode_o=0 and the long pulse arrives 8 cycles after the first post-reset cycle, not earlier.
- With LED_DIM_EN: cycle to DIM (4 short presses from OFF) -> mode_o=4, led_o pattern 1,0,0,0 repeating. The fifth press gives mode_o=0. Without the macro the fourth press gives mode_o=0.
